can_receiver: RTL and testbench

CAN_RECEIVER -- requirements
Module: can_receiver

---
 rtl/can_receiver.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_can_receiver.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_receiver.sv
// CAN 2.0A/2.0B frame receiver: decodes destuffed bits on sample_point strobes,
// checks the received CRC against the external CRC unit and checks fixed-form bits.
module can_receiver (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_point,
    input  logic        rx_bit,
    input  logic        stuff_bit_detected,
    input  logic [14:0] calculated_crc,
    output logic        crc_active,
    output logic        destuff_en,
    output logic        rx_ide,
    output logic        rx_rtr,
    output logic [10:0] rx_id_std,
    output logic [17:0] rx_id_ext,
    output logic [3:0]  rx_dlc,
    output logic [7:0]  rx_data_0,
    output logic [7:0]  rx_data_1,
    output logic [7:0]  rx_data_2,
    output logic [7:0]  rx_data_3,
    output logic [7:0]  rx_data_4,
    output logic [7:0]  rx_data_5,
    output logic [7:0]  rx_data_6,
    output logic [7:0]  rx_data_7,
    output logic [14:0] rx_crc,
    output logic        ack_drive,
    output logic        rx_done,
    output logic        crc_error,
    output logic        form_error
);

    typedef enum logic [3:0] {
        IDLE, ID_STD, RTR_1, IDE, ID_EXT, RTR_2, R_1, R_0,
        DLC, DATA, CRC, CRC_DELIM, ACK, ACK_DELIM, EOF
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [2:0]  last_byte_q, last_byte_d;
    logic [7:0]  shift_q, shift_d;
    logic [14:0] crc_latched_q, crc_latched_d;
    logic        crc_bad_q, crc_bad_d;

    logic        rx_ide_q, rx_ide_d;
    logic        rx_rtr_q, rx_rtr_d;
    logic [10:0] rx_id_std_q, rx_id_std_d;
    logic [17:0] rx_id_ext_q, rx_id_ext_d;
    logic [3:0]  rx_dlc_q, rx_dlc_d;
    logic [7:0]  rx_data_q [8];
    logic [7:0]  rx_data_d [8];
    logic [14:0] rx_crc_q, rx_crc_d;

    logic        crc_active_q, crc_active_d;
    logic        destuff_en_q, destuff_en_d;
    logic        ack_drive_q, ack_drive_d;
    logic        rx_done_q, rx_done_d;
    logic        crc_error_q, crc_error_d;
    logic        form_error_q, form_error_d;

    logic        qualified;
    logic [3:0]  dlc_next;
    logic [7:0]  byte_next;
    logic [14:0] crc_next;

    // Stuff bits are transparent to the decoder: only unflagged samples advance it.
    assign qualified = sample_point && !stuff_bit_detected;
    assign dlc_next  = {rx_dlc_q[2:0], rx_bit};
    assign byte_next = {shift_q[6:0], rx_bit};
    assign crc_next  = {rx_crc_q[13:0], rx_bit};

    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        last_byte_d   = last_byte_q;
        shift_d       = shift_q;
        crc_latched_d = crc_latched_q;
        crc_bad_d     = crc_bad_q;
        rx_ide_d      = rx_ide_q;
        rx_rtr_d      = rx_rtr_q;
        rx_id_std_d   = rx_id_std_q;
        rx_id_ext_d   = rx_id_ext_q;
        rx_dlc_d      = rx_dlc_q;
        rx_data_d     = rx_data_q;
        rx_crc_d      = rx_crc_q;
        rx_done_d     = 1'b0;
        crc_error_d   = 1'b0;
        form_error_d  = 1'b0;

        if (qualified) begin
            case (state_q)
                IDLE: if (!rx_bit) begin
                    state_d   = ID_STD;
                    bit_cnt_d = 5'd10;
                    rx_data_d = '{default: '0};
                    rx_crc_d  = '0;
                    crc_bad_d = 1'b0;
                end
                ID_STD: begin
                    rx_id_std_d = {rx_id_std_q[9:0], rx_bit};
                    if (bit_cnt_q == 5'd0) state_d = RTR_1;
                    else                   bit_cnt_d = bit_cnt_q - 5'd1;
                end
                RTR_1: begin
                    rx_rtr_d = rx_bit;
                    state_d  = IDE;
                end
                IDE: begin
                    rx_ide_d = rx_bit;
                    if (rx_bit) begin
                        state_d   = ID_EXT;
                        bit_cnt_d = 5'd17;
                    end else begin
                        state_d   = R_0;
                    end
                end
                ID_EXT: begin
                    rx_id_ext_d = {rx_id_ext_q[16:0], rx_bit};
                    if (bit_cnt_q == 5'd0) state_d = RTR_2;
                    else                   bit_cnt_d = bit_cnt_q - 5'd1;
                end
                RTR_2: begin
                    rx_rtr_d = rx_bit;
                    state_d  = R_1;
                end
                R_1: state_d = R_0;
                R_0: begin
                    state_d   = DLC;
                    bit_cnt_d = 5'd3;
                end
                DLC: begin
                    rx_dlc_d = dlc_next;
                    if (bit_cnt_q != 5'd0) begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end else if (rx_rtr_q || dlc_next == 4'd0) begin
                        state_d       = CRC;
                        bit_cnt_d     = 5'd14;
                        crc_latched_d = calculated_crc;
                    end else begin
                        state_d     = DATA;
                        bit_cnt_d   = 5'd7;
                        byte_cnt_d  = 3'd0;
                        // DLC values above 8 still carry only 8 bytes.
                        last_byte_d = dlc_next[3] ? 3'd7 : dlc_next[2:0] - 3'd1;
                    end
                end
                DATA: begin
                    shift_d = byte_next;
                    if (bit_cnt_q != 5'd0) begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end else begin
                        rx_data_d[byte_cnt_q] = byte_next;
                        if (byte_cnt_q == last_byte_q) begin
                            state_d       = CRC;
                            bit_cnt_d     = 5'd14;
                            crc_latched_d = calculated_crc;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 3'd1;
                            bit_cnt_d  = 5'd7;
                        end
                    end
                end
                CRC: begin
                    rx_crc_d = crc_next;
                    if (bit_cnt_q != 5'd0) begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end else begin
                        state_d = CRC_DELIM;
                        if (crc_next != crc_latched_q) begin
                            crc_error_d = 1'b1;
                            crc_bad_d   = 1'b1;
                        end
                    end
                end
                // A CRC failure abandons the frame without judging the delimiter.
                CRC_DELIM: begin
                    if (crc_bad_q) begin
                        state_d = IDLE;
                    end else if (!rx_bit) begin
                        form_error_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        state_d = ACK;
                    end
                end
                ACK: state_d = ACK_DELIM;
                ACK_DELIM: begin
                    if (!rx_bit) begin
                        form_error_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        state_d   = EOF;
                        bit_cnt_d = 5'd6;
                    end
                end
                EOF: begin
                    if (!rx_bit) begin
                        form_error_d = 1'b1;
                        state_d      = IDLE;
                    end else if (bit_cnt_q == 5'd0) begin
                        rx_done_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        crc_active_d = state_d inside {ID_STD, RTR_1, IDE, ID_EXT, RTR_2, R_1, R_0, DLC, DATA};
        destuff_en_d = state_d inside {ID_STD, RTR_1, IDE, ID_EXT, RTR_2, R_1, R_0, DLC, DATA, CRC};
        ack_drive_d  = (state_d == ACK);
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            last_byte_q   <= '0;
            shift_q       <= '0;
            crc_latched_q <= '0;
            crc_bad_q     <= 1'b0;
            rx_ide_q      <= 1'b0;
            rx_rtr_q      <= 1'b0;
            rx_id_std_q   <= '0;
            rx_id_ext_q   <= '0;
            rx_dlc_q      <= '0;
            // NOTE: the data bytes are visible outputs, so this small array is reset like any register.
            rx_data_q     <= '{default: '0};
            rx_crc_q      <= '0;
            crc_active_q  <= 1'b0;
            destuff_en_q  <= 1'b0;
            ack_drive_q   <= 1'b0;
            rx_done_q     <= 1'b0;
            crc_error_q   <= 1'b0;
            form_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            last_byte_q   <= last_byte_d;
            shift_q       <= shift_d;
            crc_latched_q <= crc_latched_d;
            crc_bad_q     <= crc_bad_d;
            rx_ide_q      <= rx_ide_d;
            rx_rtr_q      <= rx_rtr_d;
            rx_id_std_q   <= rx_id_std_d;
            rx_id_ext_q   <= rx_id_ext_d;
            rx_dlc_q      <= rx_dlc_d;
            rx_data_q     <= rx_data_d;
            rx_crc_q      <= rx_crc_d;
            crc_active_q  <= crc_active_d;
            destuff_en_q  <= destuff_en_d;
            ack_drive_q   <= ack_drive_d;
            rx_done_q     <= rx_done_d;
            crc_error_q   <= crc_error_d;
            form_error_q  <= form_error_d;
        end
    end

    assign crc_active = crc_active_q;
    assign destuff_en = destuff_en_q;
    assign ack_drive  = ack_drive_q;
    assign rx_done    = rx_done_q;
    assign crc_error  = crc_error_q;
    assign form_error = form_error_q;
    assign rx_ide     = rx_ide_q;
    assign rx_rtr     = rx_rtr_q;
    assign rx_id_std  = rx_id_std_q;
    assign rx_id_ext  = rx_id_ext_q;
    assign rx_dlc     = rx_dlc_q;
    assign rx_crc     = rx_crc_q;
    assign rx_data_0  = rx_data_q[0];
    assign rx_data_1  = rx_data_q[1];
    assign rx_data_2  = rx_data_q[2];
    assign rx_data_3  = rx_data_q[3];
    assign rx_data_4  = rx_data_q[4];
    assign rx_data_5  = rx_data_q[5];
    assign rx_data_6  = rx_data_q[6];
    assign rx_data_7  = rx_data_q[7];

endmodule

// File: tb/tb_can_receiver.sv
// Self-checking bench for can_receiver: frames are built as bit lists from their fields,
// and expectations follow from each bit's position in the frame.
`timescale 1ns/1ps
module tb_can_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_point = 1'b0;
    logic        rx_bit = 1'b1;
    logic        stuff_bit_detected = 1'b0;
    logic [14:0] calculated_crc = '0;
    logic        crc_active, destuff_en, rx_ide, rx_rtr, ack_drive, rx_done, crc_error, form_error;
    logic [10:0] rx_id_std;
    logic [17:0] rx_id_ext;
    logic [3:0]  rx_dlc;
    logic [14:0] rx_crc;
    logic [7:0]  rx_data_0, rx_data_1, rx_data_2, rx_data_3;
    logic [7:0]  rx_data_4, rx_data_5, rx_data_6, rx_data_7;
    logic [7:0]  dut_data [8];

    can_receiver dut (
        .clk(clk), .rst_n(rst_n), .sample_point(sample_point), .rx_bit(rx_bit),
        .stuff_bit_detected(stuff_bit_detected), .calculated_crc(calculated_crc),
        .crc_active(crc_active), .destuff_en(destuff_en), .rx_ide(rx_ide), .rx_rtr(rx_rtr),
        .rx_id_std(rx_id_std), .rx_id_ext(rx_id_ext), .rx_dlc(rx_dlc),
        .rx_data_0(rx_data_0), .rx_data_1(rx_data_1), .rx_data_2(rx_data_2), .rx_data_3(rx_data_3),
        .rx_data_4(rx_data_4), .rx_data_5(rx_data_5), .rx_data_6(rx_data_6), .rx_data_7(rx_data_7),
        .rx_crc(rx_crc), .ack_drive(ack_drive), .rx_done(rx_done),
        .crc_error(crc_error), .form_error(form_error)
    );

    assign dut_data[0] = rx_data_0;
    assign dut_data[1] = rx_data_1;
    assign dut_data[2] = rx_data_2;
    assign dut_data[3] = rx_data_3;
    assign dut_data[4] = rx_data_4;
    assign dut_data[5] = rx_data_5;
    assign dut_data[6] = rx_data_6;
    assign dut_data[7] = rx_data_7;

    always #5 clk = ~clk;

    typedef struct {
        bit          ide;
        bit          rtr;
        logic [10:0] id;
        logic [17:0] ext;
        logic [3:0]  dlc;
        logic [63:0] data;     // byte j occupies data[8*j +: 8]
        logic [14:0] crc;
        bit          bad_crc;
        int          form_at;  // offset after the last CRC bit forced dominant, 0 = none
    } frame_t;

    int checks = 0;
    int errors = 0;
    int n_done = 0, n_crc_err = 0, n_form_err = 0, n_ack = 0;

    bit          cmp_en = 1'b0;
    bit          alive = 1'b0;
    logic        exp_crc_active = 1'b0, exp_destuff = 1'b0, exp_ack = 1'b0;
    logic        exp_done = 1'b0, exp_crc_err = 1'b0, exp_form_err = 1'b0;
    logic [17:0] model_ext = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of the control and pulse outputs.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("crc_active", crc_active, exp_crc_active);
            check("destuff_en", destuff_en, exp_destuff);
            check("ack_drive", ack_drive, exp_ack);
            check("rx_done", rx_done, exp_done);
            check("crc_error", crc_error, exp_crc_err);
            check("form_error", form_error, exp_form_err);
            if (rx_done)    n_done++;
            if (crc_error)  n_crc_err++;
            if (form_error) n_form_err++;
            if (ack_drive)  n_ack++;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_crc_active"}, crc_active, 0);
        check({tag, "_destuff_en"}, destuff_en, 0);
        check({tag, "_ack_drive"}, ack_drive, 0);
        check({tag, "_pulses"}, {rx_done, crc_error, form_error}, 0);
        check({tag, "_ide_rtr"}, {rx_ide, rx_rtr}, 0);
        check({tag, "_id_std"}, rx_id_std, 0);
        check({tag, "_id_ext"}, rx_id_ext, 0);
        check({tag, "_dlc"}, rx_dlc, 0);
        check({tag, "_crc"}, rx_crc, 0);
        for (int j = 0; j < 8; j++) check({tag, "_data"}, dut_data[j], 0);
    endtask

    // One clock of stimulus; pulse expectations default to 0 for the coming edge.
    task automatic drive_cycle(input bit sp, input bit st, input bit b, input logic [14:0] c);
        @(negedge clk);
        #2;
        sample_point       = sp;
        stuff_bit_detected = st;
        rx_bit             = b;
        calculated_crc     = c;
        exp_done     = 1'b0;
        exp_crc_err  = 1'b0;
        exp_form_err = 1'b0;
    endtask

    // Expected outputs after the qualified sample of frame bit k.
    task automatic model_sample(input int k, input bit v, input int last_data, input int crc_end,
                                input bit bad);
        int off;
        off = k - crc_end;
        if (k == 0) alive = 1'b1;
        if (alive) begin
            if (off == 0 && bad) begin
                exp_crc_err = 1'b1;
            end else if (off == 1 && bad) begin
                alive = 1'b0;
            end else if (!v && (off == 1 || off == 3 || (off >= 4 && off <= 10))) begin
                exp_form_err = 1'b1;
                alive = 1'b0;
            end else if (off == 10) begin
                exp_done = 1'b1;
                alive = 1'b0;
            end
            exp_crc_active = alive && (k < last_data);
            exp_destuff    = alive && (k < crc_end);
            exp_ack        = alive && (off == 1);
        end
    endtask

    task automatic run_frame(input frame_t f, input int stuff_rel, input int abort_rel);
        bit          b[$];
        int          nbytes, last_data, crc_end, stuff_k, abort_k;
        logic [14:0] crc_field;
        b = {};
        b.push_back(1'b0);
        for (int i = 10; i >= 0; i--) b.push_back(f.id[i]);
        if (f.ide) begin
            b.push_back(1'b1);
            b.push_back(1'b1);
            for (int i = 17; i >= 0; i--) b.push_back(f.ext[i]);
            b.push_back(f.rtr);
            b.push_back(1'b0);
            b.push_back(1'b0);
        end else begin
            b.push_back(f.rtr);
            b.push_back(1'b0);
            b.push_back(1'b0);
        end
        for (int i = 3; i >= 0; i--) b.push_back(f.dlc[i]);
        nbytes = f.rtr ? 0 : ((f.dlc > 4'd8) ? 8 : int'(f.dlc));
        for (int j = 0; j < nbytes; j++)
            for (int i = 7; i >= 0; i--) b.push_back(f.data[j*8 + i]);
        last_data = b.size() - 1;
        crc_field = f.bad_crc ? (f.crc ^ 15'h2401) : f.crc;
        for (int i = 14; i >= 0; i--) b.push_back(crc_field[i]);
        crc_end = b.size() - 1;
        for (int i = 0; i < 10; i++) b.push_back(1'b1);
        if (f.form_at > 0) b[crc_end + f.form_at] = 1'b0;
        stuff_k = (stuff_rel >= 0) ? last_data - stuff_rel : -1;
        abort_k = (abort_rel >= 0) ? last_data - abort_rel : -1;

        for (int k = 0; k < b.size(); k++) begin
            if (k == abort_k) begin
                @(negedge clk);
                #2;
                rst_n = 1'b0;
                sample_point = 1'b0;
                stuff_bit_detected = 1'b0;
                alive = 1'b0;
                {exp_crc_active, exp_destuff, exp_ack, exp_done, exp_crc_err, exp_form_err} = '0;
                model_ext = '0;
                #1;
                check_all_zero("abort");
                @(negedge clk);
                #2;
                rst_n = 1'b1;
                return;
            end
            repeat ($urandom_range(0, 2)) drive_cycle(1'b0, 1'b0, 1'($urandom), 15'($urandom));
            if (k == stuff_k) drive_cycle(1'b1, 1'b1, 1'b0, 15'($urandom));
            else if ($urandom_range(0, 9) == 0) drive_cycle(1'b1, 1'b1, 1'($urandom), 15'($urandom));
            drive_cycle(1'b1, 1'b0, b[k], (k == last_data) ? f.crc : 15'($urandom));
            model_sample(k, b[k], last_data, crc_end, f.bad_crc);
            if (k == 1) begin
                check("sof_clr_crc", rx_crc, 0);
                for (int j = 0; j < 8; j++) check("sof_clr_data", dut_data[j], 0);
            end
        end
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b1, 15'h0);

        check("rx_id_std", rx_id_std, f.id);
        check("rx_ide", rx_ide, f.ide);
        check("rx_rtr", rx_rtr, f.rtr);
        if (f.ide) model_ext = f.ext;
        check("rx_id_ext", rx_id_ext, model_ext);
        check("rx_dlc", rx_dlc, f.dlc);
        for (int j = 0; j < 8; j++)
            check("rx_data", dut_data[j], (j < nbytes) ? f.data[j*8 +: 8] : 8'h00);
        check("rx_crc", rx_crc, crc_field);
    endtask

    initial begin
        frame_t f, f1;
        int d0, c0, e0, a0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        #2;
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Standard data frame with matching CRC.
        f1 = '{ide: 1'b0, rtr: 1'b0, id: 11'h123, ext: 18'h0, dlc: 4'd2,
               data: {48'h0, 8'h3C, 8'hA5}, crc: 15'h1B2C, bad_crc: 1'b0, form_at: 0};
        d0 = n_done; a0 = n_ack;
        run_frame(f1, -1, -1);
        check("std_id", rx_id_std, 11'h123);
        check("std_data0", rx_data_0, 8'hA5);
        check("std_data1", rx_data_1, 8'h3C);
        check("std_done_count", n_done - d0, 1);
        check("std_ack_seen", (n_ack - a0) > 0, 1);

        // Extended remote frame: CRC directly after DLC.
        f = '{ide: 1'b1, rtr: 1'b1, id: 11'h4D2, ext: 18'h2ABCD, dlc: 4'd4,
              data: 64'hDEAD_BEEF_0123_4567, crc: 15'h7001, bad_crc: 1'b0, form_at: 0};
        d0 = n_done;
        run_frame(f, -1, -1);
        check("ext_id_ext", rx_id_ext, 18'h2ABCD);
        check("ext_rtr", rx_rtr, 1);
        check("ext_data0_empty", rx_data_0, 8'h00);
        check("ext_done_count", n_done - d0, 1);

        // Mismatched CRC.
        f = f1;
        f.bad_crc = 1'b1;
        d0 = n_done; c0 = n_crc_err; a0 = n_ack;
        run_frame(f, -1, -1);
        check("badcrc_err_count", n_crc_err - c0, 1);
        check("badcrc_done_count", n_done - d0, 0);
        check("badcrc_ack_count", n_ack - a0, 0);

        // Dominant third EOF bit.
        f = f1;
        f.form_at = 6;
        d0 = n_done; e0 = n_form_err;
        run_frame(f, -1, -1);
        check("eof3_form_count", n_form_err - e0, 1);
        check("eof3_done_count", n_done - d0, 0);

        // Stuff bit flagged inside a 0xFF data byte.
        f = '{ide: 1'b0, rtr: 1'b0, id: 11'h7F0, ext: 18'h0, dlc: 4'd1,
              data: 64'hFF, crc: 15'h0ABC, bad_crc: 1'b0, form_at: 0};
        d0 = n_done;
        run_frame(f, 3, -1);
        check("stuff_byte", rx_data_0, 8'hFF);
        check("stuff_done_count", n_done - d0, 1);

        // Reset mid-DATA, then a fresh frame.
        f = '{ide: 1'b0, rtr: 1'b0, id: 11'h555, ext: 18'h0, dlc: 4'd3,
              data: 64'h00A1_B2C3, crc: 15'h3333, bad_crc: 1'b0, form_at: 0};
        run_frame(f, -1, 5);
        d0 = n_done;
        run_frame(f1, -1, -1);
        check("post_reset_done_count", n_done - d0, 1);
        check("post_reset_data1", rx_data_1, 8'h3C);

        for (int n = 0; n < 40; n++) begin
            f.ide     = 1'($urandom);
            f.rtr     = ($urandom_range(0, 3) == 0);
            f.id      = 11'($urandom);
            f.ext     = 18'($urandom);
            f.dlc     = 4'($urandom);
            f.data    = {$urandom, $urandom};
            f.crc     = 15'($urandom);
            f.bad_crc = ($urandom_range(0, 4) == 0);
            f.form_at = (!f.bad_crc && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, 10)) : 0;
            repeat ($urandom_range(0, 3)) drive_cycle(1'b1, 1'b0, 1'b1, 15'($urandom));
            run_frame(f, -1, -1);
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
